multi_sync_filter: RTL
======================

// Module: multi_sync_filter
// PURPOSE
//  N-channel, single-clock input conditioner for asynchronous pulse-detector inputs.
//  Each channel has:
//   - a STAGES-deep synchronizer chain,
//   - a stability (glitch/bounce) filter,
//   - registered one-cycle rise/fall event strobes.
//  Sits between the external pins and the frequency/pulse measurement logic.
//  Generalises the fixed 2-flop single-bit synchronizer in width, depth, filtering and edge reporting.
// PARAMETERS
//  N           4   number of independent channels (>=1)
//  STAGES      2   synchronizer flops per channel (>=2; elaboration error if <2)
//  FILTER_CYC  4   consecutive cycles a new synced value must hold before acceptance (>=1)
//  RST_VAL     0   reset value of the sync chain and filtered level (all channels)
// PORTS
//  clk      in   1  single clock; all state updates on posedge
//  rst_n    in   1  synchronous active-low reset
//  din      in   N  asynchronous raw inputs
//  dout     out  N  filtered, synchronized level
//  rise     out  N  one-cycle strobe: dout[i] went 0->1 on this edge
//  fall     out  N  one-cycle strobe: dout[i] went 1->0 on this edge
//  ready    out  1  high once the pipeline has flushed after reset
// BEHAVIOUR
//  Reset (rst_n==0 at a posedge):
//   - all sync flops and dout <= {N{RST_VAL}}; counters <= 0
//   - rise, fall, ready <= 0
//   - this also applies mid-operation: any count in progress is discarded and no strobe is issued on that edge.
//  Sync chain:
//   - sync[0] <= din; sync[k] <= sync[k-1]
//   - s = sync[STAGES-1]
//   - sync[0..STAGES-1] carry the ASYNC_REG attribute.
//  Filter, per channel i, counter cnt width max(1, $clog2(FILTER_CYC)):
//   - s==dout: cnt <= 0 (bounce restarts qualification)
//   - s!=dout && cnt==FILTER_CYC-1: dout <= s, cnt <= 0, strobe
//   - s!=dout otherwise: cnt <= cnt+1
//  Strobes:
//   - rise[i] = (new dout[i]==1), fall[i] = (new dout[i]==0), issued on the same edge dout changes.
//   - both are low on every other edge; rise & fall are never both set for one channel.
//  Latency:
//   - a din change captured at edge E (stable afterwards) changes dout at edge E+STAGES+FILTER_CYC-1.
//   - example: STAGES=2, FILTER_CYC=1 gives dout updating 2 edges after capture.
//  Pulse rejection:
//   - a synced pulse shorter than FILTER_CYC cycles never reaches dout.
//   - any pulse shorter than one clock may be missed entirely (no pulse stretching).
//  ready:
//   - free-running counter after reset release; asserts at the (STAGES+FILTER_CYC)th edge with rst_n==1, then stays high until the next reset.
//   - dout/strobes are valid regardless; ready only marks the end of the flush.
//  Channels are fully independent: simultaneous events on several channels each produce their own strobe on the same edge.
//  No combinational path from din to any output; all outputs are registers.
// TESTING (N=4, STAGES=2, FILTER_CYC=4, RST_VAL=0)
//  1. rst_n=0 for 3 edges with din=4'hF -> dout=0, rise=fall=0, ready=0 during reset.
//     Release -> ready=1 at 6th edge.
//  2. din[0] 0->1, captured at edge E and held -> dout[0]=1 and rise[0]=1 at edge E+5 only.
//     fall stays 0; other channels stay unchanged.
//  3. din[1] high for exactly 3 cycles then low -> dout[1], rise[1], fall[1] stay 0 throughout.
//     Repeat with 4 cycles high -> rise[1] fires, and fall[1] fires 4 cycles later.
//  4. Bounce on din[2]: high 2, low 1, high held -> dout[2] rises 4 cycles after the final high reaches s.
//     Exactly one rise[2] pulse is produced.
//  5. From dout=4'b0011, switch din to 4'b1100 on one edge -> rise=4'b1100 and fall=4'b0011 on the same edge.
//  6. din[3] held high; assert rst_n=0 when cnt=2 -> no strobe, dout=0, ready=0.
//     After release -> rise[3] at the 6th edge.

Source files
------------

// File: rtl/multi_sync_filter.sv
// multi_sync_filter: N-channel synchronizer, stability filter and edge-strobe generator
//   clk    in  1  single clock, all state on posedge
//   rst_n  in  1  synchronous active-low reset
//   din    in  N  asynchronous raw inputs
//   dout   out N  filtered, synchronized level
//   rise   out N  one-cycle strobe on dout 0->1
//   fall   out N  one-cycle strobe on dout 1->0
//   ready  out 1  high once the pipeline has flushed after reset
module multi_sync_filter #(
   parameter int unsigned N          = 4,
   parameter int unsigned STAGES     = 2,
   parameter int unsigned FILTER_CYC = 4,
   parameter bit          RST_VAL    = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] din,
   output logic [N-1:0] dout,
   output logic [N-1:0] rise,
   output logic [N-1:0] fall,
   output logic         ready
);
   localparam int unsigned   CW    = (FILTER_CYC > 1) ? $clog2(FILTER_CYC) : 1;
   localparam int unsigned   FLUSH = STAGES + FILTER_CYC;
   localparam int unsigned   RW    = $clog2(FLUSH + 1);
   localparam logic [CW-1:0] LAST  = CW'(FILTER_CYC - 1);
   localparam logic [RW-1:0] RLAST = RW'(FLUSH - 1);

   if (STAGES < 2) begin : g_stages_chk
      $error("multi_sync_filter: STAGES must be >= 2");
   end

   (* ASYNC_REG = "TRUE" *) logic [N-1:0] sync_q [STAGES];
   logic [N-1:0]  s;
   logic [N-1:0]  diff;
   logic [N-1:0]  hit;
   logic [N-1:0]  dout_q, dout_d;
   logic [N-1:0]  rise_q, rise_d;
   logic [N-1:0]  fall_q, fall_d;
   logic [CW-1:0] cnt_q [N];
   logic [CW-1:0] cnt_d [N];
   logic [RW-1:0] rcnt_q;
   logic          ready_q;

   assign s    = sync_q[STAGES-1];
   assign diff = s ^ dout_q;

   // a channel accepts the new level once it has disagreed with dout for FILTER_CYC edges;
   // any agreeing edge drops the count back to zero
   always_comb begin
      hit = '0;
      for (int i = 0; i < N; i++) begin
         hit[i]   = diff[i] && (cnt_q[i] == LAST);
         cnt_d[i] = (diff[i] && !hit[i]) ? cnt_q[i] + 1'b1 : '0;
      end
   end

   assign dout_d = dout_q ^ hit;
   assign rise_d = hit & s;
   assign fall_d = hit & ~s;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) sync_q[k] <= {N{RST_VAL}};
         for (int i = 0; i < N; i++) cnt_q[i] <= '0;
         dout_q  <= {N{RST_VAL}};
         rise_q  <= '0;
         fall_q  <= '0;
         rcnt_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         sync_q[0] <= din;
         for (int k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         // the flush counter freezes once ready is set, so it never wraps
         rcnt_q  <= ready_q ? rcnt_q : rcnt_q + 1'b1;
         ready_q <= ready_q | (rcnt_q == RLAST);
      end
   end

   assign dout  = dout_q;
   assign rise  = rise_q;
   assign fall  = fall_q;
   assign ready = ready_q;
endmodule
